// File: rtl/dpll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpll_pkg
// Description : Shared types and default sizing for the dpll lock detector.
//               lock_state_e is the 2-bit lock FSM encoding, which is also
//               exported on the debug state port.
// Revision    : 1.0 - initial release
// ============================================================================
package dpll_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_ACQUIRING = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_SLIPPING  = 2'd3
    } lock_state_e;

    localparam int ERR_W_DEF      = 16;
    localparam int LOCK_CNT_DEF   = 64;
    localparam int UNLOCK_CNT_DEF = 4;

endpackage : dpll_pkg
`default_nettype wire

// File: rtl/dpll_abs_sat.sv
`default_nettype none
// ============================================================================
// Module      : dpll_abs_sat
// Description : Combinational saturating absolute value. Takes a W-bit
//               two's-complement value and returns its magnitude in W-1 bits.
//               The most-negative input, whose magnitude does not fit,
//               saturates to all ones.
// Ports       : i_din  in  W    signed input (two's complement)
//               o_mag  out W-1  unsigned magnitude
// Revision    : 1.0 - initial release
// ============================================================================
module dpll_abs_sat #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_din,
    output logic [W-2:0] o_mag
);

    logic [W-2:0] w_neg;

    always_comb begin
        // Only the low W-1 bits of the negation are needed. For every
        // negative input except the most-negative one, the true magnitude
        // is below 2^(W-1), so those low bits are exact.
        w_neg = (~i_din[W-2:0]) + 1'b1;
        if (i_din[W-1] && (i_din[W-2:0] == '0)) begin
            o_mag = '1;
        end else if (i_din[W-1]) begin
            o_mag = w_neg;
        end else begin
            o_mag = i_din[W-2:0];
        end
    end

endmodule : dpll_abs_sat
`default_nettype wire

// File: rtl/dpll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : dpll_lock_detect
// Description : Lock detector for the dpll. Consumes the signed phase-error
//               stream from the phase detector. It declares lock after
//               LOCK_CNT consecutive samples with |err| <= lock_thresh. It
//               drops lock after UNLOCK_CNT consecutive samples with
//               |err| > unlock_thresh. The two thresholds give hysteresis.
//               Only cycles with err_valid=1 advance the detector.
// Ports       : clk            in   1        clock
//               rst            in   1        synchronous active-high reset
//               err_valid      in   1        qualifies err
//               err            in   ERR_W    signed phase error
//               lock_thresh    in   ERR_W-1  acquire window (|err| <= thr)
//               unlock_thresh  in   ERR_W-1  release window (|err| > thr)
//               locked         out  1        registered lock status
//               lock_lost      out  1        1-cycle pulse on loss of lock
//               state_o        out  2        current FSM state (debug)
// Option      : DPLL_LOCK_STATS_EN adds the statistics ports:
//               stats_clr      in   1        clear both statistics
//               loss_cnt       out  16       saturating lock-loss count
//               peak_err       out  ERR_W-1  peak |err| seen while locked
// Revision    : 1.0 - initial release
// ============================================================================
module dpll_lock_detect
    import dpll_pkg::*;
#(
    parameter int ERR_W      = ERR_W_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_valid,
    input  logic [ERR_W-1:0] err,
    input  logic [ERR_W-2:0] lock_thresh,
    input  logic [ERR_W-2:0] unlock_thresh,
`ifdef DPLL_LOCK_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      loss_cnt,
    output logic [ERR_W-2:0] peak_err,
`endif
    output logic             locked,
    output logic             lock_lost,
    output logic [1:0]       state_o
);

    localparam int c_ACQ_W  = $clog2(LOCK_CNT + 1);
    localparam int c_MISS_W = $clog2(UNLOCK_CNT + 1);

    // Counter values that complete a run when one more qualifying sample arrives
    localparam logic [c_ACQ_W-1:0]  c_ACQ_LAST  = c_ACQ_W'(LOCK_CNT - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(UNLOCK_CNT - 1);

    lock_state_e         r_state;
    lock_state_e         w_state_nxt;
    logic [c_ACQ_W-1:0]  r_acq_cnt;
    logic [c_ACQ_W-1:0]  w_acq_nxt;
    logic [c_MISS_W-1:0] r_miss_cnt;
    logic [c_MISS_W-1:0] w_miss_nxt;
    logic                r_locked;
    logic                r_lock_lost;
    logic                w_lose;

    logic [ERR_W-2:0]    w_mag;
    logic                w_in_win;
    logic                w_out_win;

    dpll_abs_sat #(
        .W (ERR_W)
    ) u_abs_sat (
        .i_din (err),
        .o_mag (w_mag)
    );

    // A sample between the two windows is neither in-window nor
    // out-of-window: it breaks acquisition but is not a miss while locked.
    assign w_in_win  = (w_mag <= lock_thresh);
    assign w_out_win = (w_mag >  unlock_thresh);

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_lose      = 1'b0;

        if (err_valid) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_in_win) begin
                        if (LOCK_CNT == 1) begin
                            w_state_nxt = ST_LOCKED;
                            w_acq_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_ACQUIRING;
                            w_acq_nxt   = c_ACQ_W'(1);
                        end
                    end
                end
                ST_ACQUIRING: begin
                    if (!w_in_win) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_acq_nxt   = '0;
                    end else if (r_acq_cnt == c_ACQ_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_acq_nxt   = '0;
                    end else begin
                        w_acq_nxt   = r_acq_cnt + c_ACQ_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (w_out_win) begin
                        if (UNLOCK_CNT == 1) begin
                            w_state_nxt = ST_UNLOCKED;
                            w_miss_nxt  = '0;
                            w_lose      = 1'b1;
                        end else begin
                            w_state_nxt = ST_SLIPPING;
                            w_miss_nxt  = c_MISS_W'(1);
                        end
                    end
                end
                ST_SLIPPING: begin
                    if (!w_out_win) begin
                        w_state_nxt = ST_LOCKED;
                        w_miss_nxt  = '0;
                    end else if (r_miss_cnt == c_MISS_LAST) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_miss_nxt  = '0;
                        w_acq_nxt   = '0;
                        w_lose      = 1'b1;
                    end else begin
                        w_miss_nxt  = r_miss_cnt + c_MISS_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                    w_acq_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_UNLOCKED;
            r_acq_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acq_cnt   <= w_acq_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_SLIPPING);
            r_lock_lost <= w_lose;
        end
    end

    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;
    assign state_o   = r_state;

`ifdef DPLL_LOCK_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: lock-loss counter and peak error while locked.
    // A clear wins over an update in the same cycle.
    // ------------------------------------------------------------------
    logic [15:0]      r_loss_cnt;
    logic [ERR_W-2:0] r_peak_err;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_loss_cnt <= '0;
            r_peak_err <= '0;
        end else begin
            if (w_lose && (r_loss_cnt != 16'hFFFF)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
            if (err_valid && r_locked && (w_mag > r_peak_err)) begin
                r_peak_err <= w_mag;
            end
        end
    end

    assign loss_cnt = r_loss_cnt;
    assign peak_err = r_peak_err;
`endif

endmodule : dpll_lock_detect
`default_nettype wire

// File: tb/tb_dpll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpll_lock_detect
// Description : Self-checking bench for dpll_lock_detect (LOCK_CNT=8,
//               UNLOCK_CNT=3). Directed scenarios plus a randomized run,
//               compared against a run-length reference model. The
//               statistics scenario is built when DPLL_LOCK_STATS_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpll_lock_detect;

    localparam int ERR_W      = 16;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             err_valid = 1'b0;
    logic [ERR_W-1:0] err = '0;
    logic [ERR_W-2:0] lock_thresh = 15'd10;
    logic [ERR_W-2:0] unlock_thresh = 15'd20;
    logic             locked;
    logic             lock_lost;
    logic [1:0]       state_o;
`ifdef DPLL_LOCK_STATS_EN
    logic             stats_clr = 1'b0;
    logic [15:0]      loss_cnt;
    logic [ERR_W-2:0] peak_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: lengths of the current good / bad runs plus lock flag
    bit m_locked;
    int m_acq;
    int m_miss;
    bit m_lost;
    int m_loss;
    int m_peak;

    dpll_lock_detect #(
        .ERR_W      (ERR_W),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .err_valid     (err_valid),
        .err           (err),
        .lock_thresh   (lock_thresh),
        .unlock_thresh (unlock_thresh),
`ifdef DPLL_LOCK_STATS_EN
        .stats_clr     (stats_clr),
        .loss_cnt      (loss_cnt),
        .peak_err      (peak_err),
`endif
        .locked        (locked),
        .lock_lost     (lock_lost),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input logic [15:0] e);
        int v;
        v = int'($signed(e));
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [1:0] m_state();
        if (m_locked) return (m_miss > 0) ? 2'd3 : 2'd2;
        return (m_acq > 0) ? 2'd1 : 2'd0;
    endfunction

    // Drive one cycle of stimulus, advance the model, settle past the edge
    task automatic step(input logic v, input logic [15:0] e, input logic c);
        int mg;
        err_valid = v;
        err       = e;
`ifdef DPLL_LOCK_STATS_EN
        stats_clr = c;
`endif
        mg = mag_of(e);
        @(posedge clk);
        m_lost = 0;
        if (rst) begin
            m_locked = 0; m_acq = 0; m_miss = 0; m_loss = 0; m_peak = 0;
        end else begin
            if (c) begin
                m_loss = 0; m_peak = 0;
            end else if (v && m_locked && mg > m_peak) begin
                m_peak = mg;
            end
            if (v) begin
                if (!m_locked) begin
                    if (mg <= int'(lock_thresh)) begin
                        m_acq++;
                        if (m_acq == LOCK_CNT) begin
                            m_locked = 1; m_acq = 0; m_miss = 0;
                        end
                    end else begin
                        m_acq = 0;
                    end
                end else begin
                    if (mg > int'(unlock_thresh)) begin
                        m_miss++;
                        if (m_miss == UNLOCK_CNT) begin
                            m_locked = 0; m_miss = 0; m_lost = 1;
                            if (!c && m_loss < 65535) m_loss++;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        lock_thresh   = 15'd10;
        unlock_thresh = 15'd20;
    endtask

    task automatic lock_up();
        for (int i = 0; i < LOCK_CNT; i++) step(1'b1, 16'd5, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state_o !== 2'd0 || locked !== 1'b0 || lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d locked=%0b lost=%0b required 0/0/0", state_o, locked, lock_lost);
        end
    endtask

    task automatic test_acquire();
        do_reset();
        for (int i = 1; i <= LOCK_CNT; i++) begin
            step(1'b1, 16'd5, 1'b0);
            checks++;
            if (locked !== (i == LOCK_CNT) || state_o !== ((i == LOCK_CNT) ? 2'd2 : 2'd1)) begin
                errors++;
                $display("FAIL acquire_%0d: locked=%0b state=%0d required %0b/%0d", i, locked, state_o,
                         (i == LOCK_CNT), (i == LOCK_CNT) ? 2 : 1);
            end
        end
        do_reset();
        for (int i = 0; i < LOCK_CNT - 1; i++) step(1'b1, 16'd5, 1'b0);
        step(1'b1, 16'd12, 1'b0);
        checks++;
        if (locked !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL acquire_break: locked=%0b state=%0d required 0/0", locked, state_o);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        for (int i = 0; i < LOCK_CNT; i++) step(1'b1, (i % 2) ? 16'd10 : 16'hFFF6, 1'b0);
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL boundary_lock_at_thresh: state=%0d required 2", state_o);
        end
        step(1'b1, 16'hFFEC, 1'b0);   // -20, exactly at release window
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL boundary_unlock_thresh: state=%0d required 2", state_o);
        end
        step(1'b1, 16'd21, 1'b0);
        checks++;
        if (state_o !== 2'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL boundary_first_miss: state=%0d locked=%0b required 3/1", state_o, locked);
        end
    endtask

    task automatic test_hysteresis();
        int bad;
        do_reset();
        lock_up();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'd15, 1'b0);
            if (state_o !== 2'd2 || locked !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hyst_mid_window: %0d cycles left LOCKED, required 0", bad);
        end
        step(1'b1, 16'hFFE7, 1'b0);
        step(1'b1, 16'hFFE7, 1'b0);
        checks++;
        if (state_o !== 2'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL hyst_slipping: state=%0d locked=%0b required 3/1", state_o, locked);
        end
        step(1'b1, 16'd0, 1'b0);
        checks++;
        if (state_o !== 2'd2 || locked !== 1'b1 || lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL hyst_recover: state=%0d locked=%0b lost=%0b required 2/1/0", state_o, locked, lock_lost);
        end
        for (int i = 0; i < UNLOCK_CNT; i++) step(1'b1, 16'hFFE7, 1'b0);
        checks++;
        if (state_o !== 2'd0 || locked !== 1'b0 || lock_lost !== 1'b1) begin
            errors++;
            $display("FAIL hyst_unlock: state=%0d locked=%0b lost=%0b required 0/0/1", state_o, locked, lock_lost);
        end
        step(1'b0, 16'h0, 1'b0);
        checks++;
        if (lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL hyst_pulse_width: lost=%0b required 0", lock_lost);
        end
    endtask

    task automatic test_gaps();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 1; i <= LOCK_CNT; i++) begin
            step(1'b1, 16'd3, 1'b0);
            for (int g = 0; g < 5; g++) begin
                step(1'b0, 16'(16'd100 + g), 1'b0);
                if (state_o !== ((i == LOCK_CNT) ? 2'd2 : 2'd1) || locked !== (i == LOCK_CNT)) bad++;
            end
        end
        checks++;
        if (bad != 0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL gaps: %0d bad gap cycles, locked=%0b, required 0 and 1", bad, locked);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        lock_up();
        step(1'b1, 16'h8000, 1'b0);
        checks++;
        if (state_o !== 2'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_miss: state=%0d locked=%0b required 3/1", state_o, locked);
        end
        unlock_thresh = 15'h7FFE;
        step(1'b1, 16'h8000, 1'b0);
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("FAIL sat_mag_above_7ffe: state=%0d required 3", state_o);
        end
        unlock_thresh = 15'h7FFF;
        step(1'b1, 16'h8000, 1'b0);
        checks++;
        if (state_o !== 2'd2 || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_mag_is_7fff: state=%0d locked=%0b required 2/1", state_o, locked);
        end
    endtask

    task automatic test_reset_slipping();
        do_reset();
        lock_up();
        step(1'b1, 16'hFFE7, 1'b0);
        step(1'b1, 16'hFFE7, 1'b0);
        rst = 1'b1;
        step(1'b1, 16'hFFE7, 1'b0);
        rst = 1'b0;
        checks++;
        if (state_o !== 2'd0 || locked !== 1'b0 || lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL reset_slipping: state=%0d locked=%0b lost=%0b required 0/0/0", state_o, locked, lock_lost);
        end
    endtask

`ifdef DPLL_LOCK_STATS_EN
    task automatic test_stats();
        do_reset();
        lock_up();
        step(1'b1, 16'd3, 1'b0);
        step(1'b1, 16'd15, 1'b0);
        step(1'b1, 16'hFFEE, 1'b0);   // -18
        step(1'b1, 16'd7, 1'b0);
        checks++;
        if (peak_err !== 15'd18) begin
            errors++;
            $display("FAIL stats_peak: peak=%0d required 18", peak_err);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < UNLOCK_CNT; i++) step(1'b1, 16'hFFE7, 1'b0);
            if (k == 0) lock_up();
        end
        checks++;
        if (loss_cnt !== 16'd2 || peak_err !== 15'd25) begin
            errors++;
            $display("FAIL stats_loss2: loss=%0d peak=%0d required 2/25", loss_cnt, peak_err);
        end
        lock_up();
        step(1'b1, 16'hFFE7, 1'b0);
        step(1'b1, 16'hFFE7, 1'b0);
        step(1'b1, 16'hFFE7, 1'b1);
        checks++;
        if (loss_cnt !== 16'd0 || peak_err !== 15'd0 || lock_lost !== 1'b1) begin
            errors++;
            $display("FAIL stats_clr_priority: loss=%0d peak=%0d lost=%0b required 0/0/1", loss_cnt, peak_err, lock_lost);
        end
        step(1'b0, 16'h0, 1'b0);
    endtask
`endif

    task automatic test_random();
        int bad;
        int hi;
        int mg;
        logic [15:0] e;
        do_reset();
        bad = 0;
        for (int b = 0; b < 60; b++) begin
            lock_thresh   = 15'($urandom_range(5, 15));
            unlock_thresh = 15'($urandom_range(8, 25));
            case ($urandom_range(0, 2))
                0:       hi = 12;
                1:       hi = 25;
                default: hi = 60;
            endcase
            for (int n = 0, len = int'($urandom_range(5, 30)); n < len; n++) begin
                mg = int'($urandom_range(0, hi));
                e  = ($urandom_range(0, 1) == 1) ? 16'(-mg) : 16'(mg);
                if ($urandom_range(0, 49) == 0) e = 16'h8000;
                rst = ($urandom_range(0, 299) == 0);
                step(($urandom_range(0, 9) < 8), e, ($urandom_range(0, 99) == 0));
                rst = 1'b0;
                checks++;
                if (locked !== m_locked || lock_lost !== m_lost || state_o !== m_state()
`ifdef DPLL_LOCK_STATS_EN
                    || loss_cnt !== 16'(m_loss) || peak_err !== 15'(m_peak)
`endif
                   ) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random_b%0d_n%0d: locked=%0b lost=%0b state=%0d required %0b/%0b/%0d",
                                 b, n, locked, lock_lost, state_o, m_locked, m_lost, m_state());
                end
            end
        end
    endtask

    initial begin
        m_locked = 0; m_acq = 0; m_miss = 0; m_lost = 0; m_loss = 0; m_peak = 0;
        test_reset();
        test_acquire();
        test_boundary();
        test_hysteresis();
        test_gaps();
        test_saturation();
        test_reset_slipping();
`ifdef DPLL_LOCK_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dpll_lock_detect
`default_nettype wire
